// File: rtl/approx_mult_pipe.sv
// approx_mult_pipe: 3-stage pipelined unsigned W x W multiplier with a
// per-beat exact/approximate mode.
//   Stage 1 registers the operands.
//   Stage 2 reduces the partial products to carry-save rows.
//   Stage 3 performs the final add.
// In approximate mode the APX_COLS lowest product columns are compressed
// with a carry-free OR instead of being summed.
// Ports:
//   clk, rst              rising-edge clock, async active-high reset
//   in_valid/in_ready     operand handshake (a, b, approx)
//   out_valid/out_ready   result handshake (product, out_approx)
module approx_mult_pipe #(
    parameter int unsigned W        = 8,
    parameter int unsigned APX_COLS = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [W-1:0]      a,
    input  logic [W-1:0]      b,
    input  logic              approx,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [2*W-1:0]    product,
    output logic              out_approx
);

    localparam int unsigned PW = 2 * W;

    // Bit c is set for every product column that is OR-compressed in approx mode.
    function automatic logic [PW-1:0] low_mask_f();
        logic [PW-1:0] m;
        m = '0;
        for (int unsigned c = 0; c < PW; c++) begin
            m[c] = (c < APX_COLS);
        end
        return m;
    endfunction

    localparam logic [PW-1:0] LOW_MASK = low_mask_f();

    // Global stall: every stage moves together, or every stage holds.
    logic advance;
    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    // Stage 1: operand register.
    logic          s1_valid;
    logic          s1_approx;
    logic [W-1:0]  s1_a;
    logic [W-1:0]  s1_b;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_approx <= 1'b0;
            s1_a      <= '0;
            s1_b      <= '0;
        end else if (advance) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_approx <= approx;
                s1_a      <= a;
                s1_b      <= b;
            end
        end
    end

    // Stage 2 logic: one partial-product row per multiplier bit, folded into
    // (sum, carry) by a chain of 3:2 compressors. In approx mode the low
    // columns are stripped from each row and OR-ed into a separate row, so no
    // carry is generated from or into them.
    logic [PW-1:0] cs_sum;
    logic [PW-1:0] cs_carry;
    logic [PW-1:0] low_or;
    logic [PW-1:0] row;
    logic [PW-1:0] t_sum;
    logic [PW-1:0] t_carry;

    always_comb begin
        cs_sum   = '0;
        cs_carry = '0;
        low_or   = '0;
        row      = '0;
        t_sum    = '0;
        t_carry  = '0;
        for (int j = 0; j < W; j++) begin
            row = PW'(s1_a & {W{s1_b[j]}}) << j;
            if (s1_approx) begin
                low_or = low_or | (row & LOW_MASK);
                row    = row & ~LOW_MASK;
            end
            t_sum    = cs_sum ^ cs_carry ^ row;
            t_carry  = ((cs_sum & cs_carry) | (cs_sum & row) | (cs_carry & row)) << 1;
            cs_sum   = t_sum;
            cs_carry = t_carry;
        end
    end

    // Stage 2: carry-save register.
    logic          s2_valid;
    logic          s2_approx;
    logic [PW-1:0] s2_sum;
    logic [PW-1:0] s2_carry;
    logic [PW-1:0] s2_low;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid  <= 1'b0;
            s2_approx <= 1'b0;
            s2_sum    <= '0;
            s2_carry  <= '0;
            s2_low    <= '0;
        end else if (advance) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_approx <= s1_approx;
                s2_sum    <= cs_sum;
                s2_carry  <= cs_carry;
                s2_low    <= low_or;
            end
        end
    end

    // Stage 3: final add. The high part has no bits in the low columns and the
    // OR row has none above them, so merging them with OR equals adding them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_approx <= 1'b0;
            product    <= '0;
        end else if (advance) begin
            out_valid <= s2_valid;
            if (s2_valid) begin
                out_approx <= s2_approx;
                product    <= (s2_sum + s2_carry) | s2_low;
            end
        end
    end

endmodule

// File: tb/tb_approx_mult_pipe.sv
// Directed testbench for approx_mult_pipe: W=8/APX_COLS=4 and W=16/APX_COLS=0.
module tb_approx_mult_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b0;

    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  a = '0;
    logic [7:0]  b = '0;
    logic        approx = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] product;
    logic        out_approx;

    logic        in_valid1 = 1'b0;
    logic        in_ready1;
    logic [15:0] a1 = '0;
    logic [15:0] b1 = '0;
    logic        approx1 = 1'b0;
    logic        out_valid1;
    logic        out_ready1 = 1'b1;
    logic [31:0] product1;
    logic        out_approx1;

    int n_cmp = 0;
    int n_err = 0;

    longint unsigned exp_q[$];
    bit              expm_q[$];

    logic [7:0] sa [16] = '{8'd255, 8'd3, 8'd0, 8'd1, 8'd128, 8'd200, 8'd17, 8'd99,
                            8'd255, 8'd15, 8'd64, 8'd171, 8'd85, 8'd240, 8'd7, 8'd250};
    logic [7:0] sb [16] = '{8'd255, 8'd3, 8'd77, 8'd1, 8'd2, 8'd150, 8'd33, 8'd99,
                            8'd1, 8'd15, 8'd64, 8'd205, 8'd170, 8'd15, 8'd9, 8'd250};
    bit         sm [16] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1,
                            1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

    approx_mult_pipe #(.W(8), .APX_COLS(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .approx(approx),
        .out_valid(out_valid), .out_ready(out_ready),
        .product(product), .out_approx(out_approx)
    );

    approx_mult_pipe #(.W(16), .APX_COLS(0)) dut16 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid1), .in_ready(in_ready1),
        .a(a1), .b(b1), .approx(approx1),
        .out_valid(out_valid1), .out_ready(out_ready1),
        .product(product1), .out_approx(out_approx1)
    );

    always #5 clk = ~clk;

    // Reference: exact weighted sum of high-column partial products plus a
    // carry-free OR of each low column.
    function automatic longint unsigned ref_mul(longint unsigned av, longint unsigned bv,
                                                bit apx, int w, int cols);
        longint unsigned h = 0;
        longint unsigned l = 0;
        for (int i = 0; i < w; i++) begin
            for (int j = 0; j < w; j++) begin
                if (av[i] && bv[j]) begin
                    if (apx && (i + j) < cols) l = l | (64'd1 << (i + j));
                    else                       h = h + (64'd1 << (i + j));
                end
            end
        end
        return h + l;
    endfunction

    task automatic test_reset();
        #2 rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_cmp++; if (product !== 16'd0) begin n_err++; $display("FAIL reset_product: got %0d want 0", product); end
        n_cmp++; if (out_approx !== 1'b0) begin n_err++; $display("FAIL reset_out_approx: got %b want 0", out_approx); end
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        n_cmp++; if (product1 !== 32'd0) begin n_err++; $display("FAIL reset_product16: got %0d want 0", product1); end
    endtask

    task automatic test_exact_latency();
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b1; a = 8'd255; b = 8'd255; approx = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL latency_edge1: got %b want 0", out_valid); end
        @(negedge clk);
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL latency_edge2: got %b want 0", out_valid); end
        @(negedge clk);
        n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL latency_edge3: got %b want 1", out_valid); end
        n_cmp++; if (product !== 16'd65025) begin n_err++; $display("FAIL exact_255x255: got %0d want 65025", product); end
        n_cmp++; if (out_approx !== 1'b0) begin n_err++; $display("FAIL exact_tag: got %b want 0", out_approx); end
    endtask

    task automatic test_approx();
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b1; a = 8'd255; b = 8'd255; approx = 1'b1;
        @(negedge clk);
        a = 8'd3; b = 8'd3; approx = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL approx_valid0: got %b want 1", out_valid); end
        n_cmp++; if (product !== 16'd64991) begin n_err++; $display("FAIL approx_255x255: got %0d want 64991", product); end
        n_cmp++; if (out_approx !== 1'b1) begin n_err++; $display("FAIL approx_tag0: got %b want 1", out_approx); end
        @(negedge clk);
        n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL approx_valid1: got %b want 1", out_valid); end
        n_cmp++; if (product !== 16'd7) begin n_err++; $display("FAIL approx_3x3: got %0d want 7", product); end
        n_cmp++; if (out_approx !== 1'b1) begin n_err++; $display("FAIL approx_tag1: got %b want 1", out_approx); end
        @(negedge clk);
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL approx_drain: got %b want 0", out_valid); end
    endtask

    task automatic test_back_to_back();
        int sent = 0;
        int got = 0;
        int first = -1;
        int last = -1;
        longint unsigned e;
        bit em;
        exp_q.delete(); expm_q.delete();
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 60 && got < 16; cyc++) begin
            @(negedge clk);
            if (out_valid) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++; $display("FAIL stream_spurious: got product %0d want no beat", product);
                end else begin
                    e = exp_q.pop_front(); em = expm_q.pop_front();
                    if (product !== 16'(e) || out_approx !== em) begin
                        n_err++;
                        $display("FAIL stream_beat%0d: got %0d/%b want %0d/%b", got, product, out_approx, e, em);
                    end
                end
                if (first < 0) first = cyc;
                last = cyc;
                got++;
            end
            if (sent < 16) begin
                in_valid = 1'b1; a = sa[sent]; b = sb[sent]; approx = sm[sent];
                exp_q.push_back(ref_mul(64'(sa[sent]), 64'(sb[sent]), sm[sent], 8, 4));
                expm_q.push_back(sm[sent]);
                sent++;
            end else begin
                in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        n_cmp++; if (got !== 16) begin n_err++; $display("FAIL stream_count: got %0d want 16", got); end
        n_cmp++; if (last - first !== 15) begin n_err++; $display("FAIL stream_rate: got span %0d want 15", last - first); end
    endtask

    task automatic test_backpressure();
        int got = 0;
        longint unsigned e;
        longint unsigned e0;
        exp_q.delete(); expm_q.delete();
        @(negedge clk);
        out_ready = 1'b0;
        in_valid = 1'b1; a = 8'd200; b = 8'd200; approx = 1'b0;
        exp_q.push_back(64'd40000);
        @(negedge clk);
        a = 8'd255; b = 8'd255; approx = 1'b1;
        exp_q.push_back(64'd64991);
        @(negedge clk);
        a = 8'd13; b = 8'd11; approx = 1'b1;
        exp_q.push_back(ref_mul(64'd13, 64'd11, 1'b1, 8, 4));
        @(negedge clk);
        // Decoy beat held while stalled; it must never be accepted.
        a = 8'd9; b = 8'd9; approx = 1'b0;
        e0 = exp_q[0];
        for (int k = 0; k < 5; k++) begin
            n_cmp++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || product !== 16'(e0)) begin
                n_err++;
                $display("FAIL stall_cycle%0d: got rdy=%b vld=%b prod=%0d want rdy=0 vld=1 prod=%0d",
                         k, in_ready, out_valid, product, e0);
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 10 && got < 3; cyc++) begin
            if (out_valid) begin
                e = exp_q.pop_front();
                n_cmp++;
                if (product !== 16'(e)) begin
                    n_err++; $display("FAIL drain_beat%0d: got %0d want %0d", got, product, e);
                end
                got++;
            end
            @(negedge clk);
        end
        n_cmp++; if (got !== 3) begin n_err++; $display("FAIL drain_count: got %0d want 3", got); end
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL drain_extra: got %b want 0", out_valid); end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b1; a = 8'd255; b = 8'd255; approx = 1'b1;
        @(negedge clk);
        a = 8'd200; b = 8'd100;
        @(negedge clk);
        a = 8'd77; b = 8'd66;
        @(negedge clk);
        in_valid = 1'b0;
        n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL midrst_pre: got %b want 1", out_valid); end
        rst = 1'b1;
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL midrst_valid: got %b want 0", out_valid); end
        n_cmp++; if (product !== 16'd0) begin n_err++; $display("FAIL midrst_product: got %0d want 0", product); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL midrst_ready: got %b want 1", in_ready); end
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL midrst_flush0: got %b want 0", out_valid); end
        in_valid = 1'b1; a = 8'd10; b = 8'd12; approx = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL midrst_flush1: got %b want 0", out_valid); end
        @(negedge clk);
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL midrst_flush2: got %b want 0", out_valid); end
        @(negedge clk);
        n_cmp++; if (out_valid !== 1'b1 || product !== 16'd120 || out_approx !== 1'b0) begin
            n_err++; $display("FAIL midrst_next: got vld=%b %0d/%b want vld=1 120/0", out_valid, product, out_approx);
        end
    endtask

    task automatic test_w16_nocols();
        logic [15:0] va [5] = '{16'd65535, 16'd1234, 16'd40000, 16'd0, 16'd256};
        logic [15:0] vb [5] = '{16'd65535, 16'd5678, 16'd3, 16'd77, 16'd255};
        logic [31:0] ve [5] = '{32'd4294836225, 32'd7006652, 32'd120000, 32'd0, 32'd65280};
        int sent = 0;
        int got = 0;
        out_ready1 = 1'b1;
        for (int cyc = 0; cyc < 30 && got < 5; cyc++) begin
            @(negedge clk);
            if (out_valid1) begin
                n_cmp++;
                if (got >= 5) begin
                    n_err++; $display("FAIL w16_spurious: got %0d", product1);
                end else if (product1 !== ve[got] || out_approx1 !== 1'b1) begin
                    n_err++;
                    $display("FAIL w16_beat%0d: got %0d/%b want %0d/1", got, product1, out_approx1, ve[got]);
                end
                got++;
            end
            if (sent < 5) begin
                in_valid1 = 1'b1; a1 = va[sent]; b1 = vb[sent]; approx1 = 1'b1;
                sent++;
            end else begin
                in_valid1 = 1'b0;
            end
        end
        in_valid1 = 1'b0;
        n_cmp++; if (got !== 5) begin n_err++; $display("FAIL w16_count: got %0d want 5", got); end
    endtask

    initial begin
        test_reset();
        test_exact_latency();
        test_approx();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        test_w16_nocols();
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
